// File: rtl/dll_scheduler_if.sv
// DLL-side bus of dll_scheduler: operand issue towards the shared DLL unit and its tagged result.
// master = scheduler, slave = DLL discriminator/divider.
interface dll_scheduler_if #(
  parameter int unsigned CH_ID_WIDTH = 2,
  parameter int unsigned I2Q2_WIDTH  = 37,
  parameter int unsigned SHIFT_WIDTH = 10
);

  logic [CH_ID_WIDTH-1:0] dll_tag;
  logic [I2Q2_WIDTH-1:0]  dll_i2q2_early;
  logic [I2Q2_WIDTH-1:0]  dll_i2q2_late;
  logic                   dll_start;
  logic                   dll_result_ready;
  logic [CH_ID_WIDTH-1:0] dll_result_tag;
  logic                   dll_shift_direction;
  logic [SHIFT_WIDTH-1:0] dll_shift_amount;

  modport master (
    output dll_tag, dll_i2q2_early, dll_i2q2_late, dll_start,
    input  dll_result_ready, dll_result_tag, dll_shift_direction, dll_shift_amount
  );

  modport slave (
    input  dll_tag, dll_i2q2_early, dll_i2q2_late, dll_start,
    output dll_result_ready, dll_result_tag, dll_shift_direction, dll_shift_amount
  );

endinterface

// File: rtl/dll_scheduler.sv
// Round-robin scheduler sharing one multi-cycle DLL unit among NUM_CH tracking channels.
// Optional WAIT watchdog with sticky timeout_err port: define DLL_SCHED_TIMEOUT_EN.
module dll_scheduler #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_ID_WIDTH = 2,
  parameter int unsigned I2Q2_WIDTH  = 37,
  parameter int unsigned SHIFT_WIDTH = 10,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic                         clk,
  input  logic                         global_reset,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*I2Q2_WIDTH-1:0] req_early,
  input  logic [NUM_CH*I2Q2_WIDTH-1:0] req_late,
  dll_scheduler_if.master              dll,
  output logic [NUM_CH-1:0]            resp_valid,
  output logic                         resp_shift_direction,
  output logic [SHIFT_WIDTH-1:0]       resp_shift_amount,
  output logic                         busy,
  output logic [NUM_CH-1:0]            overrun,
  output logic                         tag_err
`ifdef DLL_SCHED_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_CH-1:0]     pending_q;
  logic [I2Q2_WIDTH-1:0] slot_early_q [NUM_CH];
  logic [I2Q2_WIDTH-1:0] slot_late_q  [NUM_CH];
  logic [IDX_W-1:0]      rr_ptr_q;

  logic                  grant_found;
  logic [IDX_W-1:0]      grant_sel;
  int unsigned           scan_idx;
  logic                  grant_en;
  logic                  result_hit;
  logic                  result_bad;
  logic                  timeout_hit;

  // Round-robin search: first pending channel at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = '0;
    scan_idx    = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scan_idx = 32'(rr_ptr_q) + i;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (!grant_found && pending_q[scan_idx[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_sel   = scan_idx[IDX_W-1:0];
      end
    end
  end

`ifdef DLL_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q;

  // Counts WAIT cycles; cleared while in ISSUE so it starts at zero on WAIT entry.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      wait_cnt_q  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      else                   wait_cnt_q <= '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (result_hit)       state_d = S_IDLE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded controls; a matching result wins over a same-cycle timeout.
  always_comb begin
    grant_en    = 1'b0;
    result_hit  = 1'b0;
    result_bad  = 1'b0;
    timeout_hit = 1'b0;
    if (state_q == S_IDLE && grant_found) grant_en = 1'b1;
    if (dll.dll_result_ready) begin
      if (state_q == S_WAIT && dll.dll_result_tag == dll.dll_tag) result_hit = 1'b1;
      else                                                         result_bad = 1'b1;
    end
`ifdef DLL_SCHED_TIMEOUT_EN
    if (state_q == S_WAIT && !result_hit && wait_cnt_q == CNT_W'(TIMEOUT - 1))
      timeout_hit = 1'b1;
`endif
  end

  // Per-channel capture; a granted slot hands its old data out while taking the new request.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      pending_q <= '0;
      overrun   <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        slot_early_q[k] <= '0;
        slot_late_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (req_valid[k]) begin
          slot_early_q[k] <= req_early[k*I2Q2_WIDTH +: I2Q2_WIDTH];
          slot_late_q[k]  <= req_late[k*I2Q2_WIDTH +: I2Q2_WIDTH];
          pending_q[k]    <= 1'b1;
          if (pending_q[k] && !(grant_en && grant_sel == IDX_W'(k))) overrun[k] <= 1'b1;
        end else if (grant_en && grant_sel == IDX_W'(k)) begin
          pending_q[k] <= 1'b0;
        end
      end
    end
  end

  // Issue side: operands and tag stay frozen from grant until the next grant.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      rr_ptr_q           <= '0;
      dll.dll_start      <= 1'b0;
      dll.dll_tag        <= '0;
      dll.dll_i2q2_early <= '0;
      dll.dll_i2q2_late  <= '0;
    end else begin
      dll.dll_start <= grant_en;
      if (grant_en) begin
        dll.dll_tag        <= CH_ID_WIDTH'(grant_sel);
        dll.dll_i2q2_early <= slot_early_q[grant_sel];
        dll.dll_i2q2_late  <= slot_late_q[grant_sel];
        rr_ptr_q           <= (grant_sel == IDX_W'(NUM_CH - 1)) ? '0 : grant_sel + IDX_W'(1);
      end
    end
  end

  // Response side and status flags.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      resp_valid           <= '0;
      resp_shift_direction <= 1'b0;
      resp_shift_amount    <= '0;
      busy                 <= 1'b0;
      tag_err              <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++)
        resp_valid[k] <= result_hit && (dll.dll_tag == CH_ID_WIDTH'(k));
      if (result_hit) begin
        resp_shift_direction <= dll.dll_shift_direction;
        resp_shift_amount    <= dll.dll_shift_amount;
      end
      busy <= (state_d != S_IDLE);
      if (result_bad) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dll_scheduler.sv
// Directed self-checking bench for dll_scheduler; the bench plays the DLL unit.
// Build with DLL_SCHED_TIMEOUT_EN defined to also exercise the WAIT watchdog (TIMEOUT=16).
module tb_dll_scheduler;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned IW  = 37;
  localparam int unsigned SW  = 10;

  logic              clk = 1'b0;
  logic              global_reset;
  logic [NCH-1:0]    req_valid;
  logic [NCH*IW-1:0] req_early;
  logic [NCH*IW-1:0] req_late;
  logic [NCH-1:0]    resp_valid;
  logic              resp_shift_direction;
  logic [SW-1:0]     resp_shift_amount;
  logic              busy;
  logic [NCH-1:0]    overrun;
  logic              tag_err;
`ifdef DLL_SCHED_TIMEOUT_EN
  logic              timeout_err;
`endif

  int checks   = 0;
  int failures = 0;
  int starts   = 0;
  logic [CW-1:0] tag;

  dll_scheduler_if #(.CH_ID_WIDTH(CW), .I2Q2_WIDTH(IW), .SHIFT_WIDTH(SW)) dll_bus ();

  dll_scheduler #(
    .NUM_CH(NCH), .CH_ID_WIDTH(CW), .I2Q2_WIDTH(IW), .SHIFT_WIDTH(SW), .TIMEOUT(16)
  ) dut (
    .clk                  (clk),
    .global_reset         (global_reset),
    .req_valid            (req_valid),
    .req_early            (req_early),
    .req_late             (req_late),
    .dll                  (dll_bus),
    .resp_valid           (resp_valid),
    .resp_shift_direction (resp_shift_direction),
    .resp_shift_amount    (resp_shift_amount),
    .busy                 (busy),
    .overrun              (overrun),
    .tag_err              (tag_err)
`ifdef DLL_SCHED_TIMEOUT_EN
    ,
    .timeout_err          (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    global_reset = 1'b1;
    req_valid    = '0;
    dll_bus.dll_result_ready    = 1'b0;
    dll_bus.dll_result_tag      = '0;
    dll_bus.dll_shift_direction = 1'b0;
    dll_bus.dll_shift_amount    = '0;
    tick();
    global_reset = 1'b0;
  endtask

  task automatic load(input int k, input logic [IW-1:0] e, input logic [IW-1:0] l);
    req_early[k*IW +: IW] = e;
    req_late[k*IW +: IW]  = l;
  endtask

  task automatic pulse_req(input logic [NCH-1:0] mask);
    req_valid = mask;
    tick();
    req_valid = '0;
  endtask

  // Present one DLL result for a single cycle, then scrub the data lines.
  task automatic respond(input logic [CW-1:0] t, input logic dir, input logic [SW-1:0] amt);
    dll_bus.dll_result_ready    = 1'b1;
    dll_bus.dll_result_tag      = t;
    dll_bus.dll_shift_direction = dir;
    dll_bus.dll_shift_amount    = amt;
    tick();
    dll_bus.dll_result_ready    = 1'b0;
    dll_bus.dll_result_tag      = '0;
    dll_bus.dll_shift_direction = 1'b0;
    dll_bus.dll_shift_amount    = '0;
  endtask

  task automatic wait_start(input int budget, output logic [CW-1:0] t);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!dll_bus.dll_start && n < budget);
    check("start_seen", 64'(dll_bus.dll_start), 64'(1));
    if (dll_bus.dll_start) starts++;
    t = dll_bus.dll_tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    req_early = '0;
    req_late  = '0;
    do_reset();

    // Reset state
    check("rst_start", 64'(dll_bus.dll_start), 64'(0));
    check("rst_tag", 64'(dll_bus.dll_tag), 64'(0));
    check("rst_early", 64'(dll_bus.dll_i2q2_early), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_resp", 64'(resp_valid), 64'(0));
    check("rst_flags", 64'({overrun, tag_err}), 64'(0));

    // Single request on channel 2: two-cycle latency to dll_start
    load(2, 37'h100, 37'h80);
    pulse_req(4'b0100);
    check("lat_c1_start", 64'(dll_bus.dll_start), 64'(0));
    tick();
    check("lat_c2_start", 64'(dll_bus.dll_start), 64'(1));
    check("single_tag", 64'(dll_bus.dll_tag), 64'(2));
    check("single_early", 64'(dll_bus.dll_i2q2_early), 64'h100);
    check("single_late", 64'(dll_bus.dll_i2q2_late), 64'h80);
    check("single_busy", 64'(busy), 64'(1));
    tick();
    check("start_one_cycle", 64'(dll_bus.dll_start), 64'(0));
    check("wait_hold_early", 64'(dll_bus.dll_i2q2_early), 64'h100);
    respond(2'd2, 1'b0, 10'd5);
    check("single_resp", 64'(resp_valid), 64'b0100);
    check("single_amt", 64'(resp_shift_amount), 64'(5));
    check("single_dir", 64'(resp_shift_direction), 64'(0));
    check("single_idle", 64'(busy), 64'(0));
    tick();
    check("resp_strobe_1cyc", 64'(resp_valid), 64'(0));
    check("resp_amt_hold", 64'(resp_shift_amount), 64'(5));

    // All four channels at once: served 0,1,2,3
    do_reset();
    starts = 0;
    for (int k = 0; k < 4; k++) load(k, IW'(37'h10 + 37'(k)), IW'(37'h20 + 37'(k)));
    pulse_req(4'b1111);
    for (int k = 0; k < 4; k++) begin
      wait_start(8, tag);
      check("all_tag", 64'(tag), 64'(k));
      check("all_early", 64'(dll_bus.dll_i2q2_early), 64'(37'h10 + 37'(k)));
      check("all_late", 64'(dll_bus.dll_i2q2_late), 64'(37'h20 + 37'(k)));
      tick();
      respond(CW'(k), (k % 2) == 1, SW'(k + 1));
      check("all_resp", 64'(resp_valid), 64'(1) << k);
      check("all_amt", 64'(resp_shift_amount), 64'(k + 1));
      check("all_dir", 64'(resp_shift_direction), 64'(k % 2));
    end
    repeat (3) tick();
    check("all_start_count", 64'(starts), 64'(4));
    check("all_drained", 64'(busy), 64'(0));

    // Fairness: channel 0 re-requests during its own service
    do_reset();
    load(0, 37'hA0, 37'hB0);
    load(1, 37'hA1, 37'hB1);
    load(3, 37'hA3, 37'hB3);
    pulse_req(4'b1011);
    wait_start(8, tag);
    check("fair_g0", 64'(tag), 64'(0));
    load(0, 37'hC0, 37'hD0);
    pulse_req(4'b0001);
    respond(2'd0, 1'b0, 10'd1);
    wait_start(8, tag);
    check("fair_g1", 64'(tag), 64'(1));
    tick();
    respond(2'd1, 1'b0, 10'd2);
    wait_start(8, tag);
    check("fair_g2_ch3", 64'(tag), 64'(3));
    check("fair_ch3_early", 64'(dll_bus.dll_i2q2_early), 64'hA3);
    tick();
    respond(2'd3, 1'b1, 10'd3);
    wait_start(8, tag);
    check("fair_g3_ch0", 64'(tag), 64'(0));
    check("fair_ch0_early", 64'(dll_bus.dll_i2q2_early), 64'hC0);
    tick();
    respond(2'd0, 1'b0, 10'd4);
    check("fair_no_overrun", 64'(overrun), 64'(0));

    // Overrun: channel 1 requests twice while channel 0 is in flight
    do_reset();
    load(0, 37'h1, 37'h2);
    pulse_req(4'b0001);
    wait_start(8, tag);
    check("ovr_g0", 64'(tag), 64'(0));
    tick();
    load(1, 37'h111, 37'h11);
    pulse_req(4'b0010);
    check("ovr_first_clean", 64'(overrun), 64'(0));
    load(1, 37'h1F_0000_0001, 37'h22);
    pulse_req(4'b0010);
    check("ovr_flag", 64'(overrun), 64'b0010);
    respond(2'd0, 1'b1, 10'd7);
    wait_start(8, tag);
    check("ovr_g1", 64'(tag), 64'(1));
    check("ovr_newer_early", 64'(dll_bus.dll_i2q2_early), 64'h1F_0000_0001);
    check("ovr_newer_late", 64'(dll_bus.dll_i2q2_late), 64'h22);
    tick();
    respond(2'd1, 1'b0, 10'd8);
    check("ovr_resp", 64'(resp_valid), 64'b0010);
    check("ovr_sticky", 64'(overrun), 64'b0010);

    // Tag error: wrong tag in WAIT is ignored, the right one completes
    do_reset();
    load(1, 37'h55, 37'h66);
    pulse_req(4'b0010);
    wait_start(8, tag);
    check("tag_g1", 64'(tag), 64'(1));
    tick();
    respond(2'd3, 1'b1, 10'd9);
    check("tag_err_set", 64'(tag_err), 64'(1));
    check("tag_no_resp", 64'(resp_valid), 64'(0));
    check("tag_still_busy", 64'(busy), 64'(1));
    tick();
    check("tag_no_restart", 64'(dll_bus.dll_start), 64'(0));
    respond(2'd1, 1'b1, 10'h3FF);
    check("tag_good_resp", 64'(resp_valid), 64'b0010);
    check("tag_good_amt", 64'(resp_shift_amount), 64'h3FF);
    check("tag_good_dir", 64'(resp_shift_direction), 64'(1));

    // Reset mid-WAIT, then the stale result arrives in IDLE
    do_reset();
    load(2, 37'h77, 37'h88);
    pulse_req(4'b0100);
    wait_start(8, tag);
    tick();
    do_reset();
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_tag", 64'(dll_bus.dll_tag), 64'(0));
    check("midrst_tag_err", 64'(tag_err), 64'(0));
    respond(2'd2, 1'b1, 10'd12);
    check("stale_tag_err", 64'(tag_err), 64'(1));
    check("stale_no_resp", 64'(resp_valid), 64'(0));
    check("stale_amt", 64'(resp_shift_amount), 64'(0));

`ifdef DLL_SCHED_TIMEOUT_EN
    // Watchdog: no result for channel 0, channel 2 issued afterwards
    do_reset();
    load(0, 37'h3, 37'h4);
    load(2, 37'h5, 37'h6);
    pulse_req(4'b0101);
    wait_start(8, tag);
    check("to_g0", 64'(tag), 64'(0));
    tick();
    repeat (15) tick();
    check("to_not_yet", 64'(timeout_err), 64'(0));
    tick();
    check("to_err", 64'(timeout_err), 64'(1));
    check("to_no_resp", 64'(resp_valid), 64'(0));
    wait_start(4, tag);
    check("to_next_ch2", 64'(tag), 64'(2));
    respond(2'd0, 1'b0, 10'd1);
    check("to_late_tag_err", 64'(tag_err), 64'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dll_scheduler.md
Name: dll_scheduler

Overview:
- Shares one multi-cycle DLL discriminator/divider unit among NUM_CH tracking channels.
- Latches each channel's early/late I2Q2 request and picks one pending channel round-robin.
- Presents that channel's operands and tag to the DLL and holds them stable until the tagged result returns.
- Routes shift_direction/shift_amount back to the owning channel as a one-cycle response strobe.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- CH_ID_WIDTH, 2, tag width; must satisfy 2^CH_ID_WIDTH >= NUM_CH.
- I2Q2_WIDTH, 37, width of each early/late I2Q2 operand.
- SHIFT_WIDTH, 10, DLL shift_amount width.
- TIMEOUT, 1023, max cycles in WAIT before abort (used only with DLL_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- global_reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel one-cycle request strobe.
- req_early  in  NUM_CH*I2Q2_WIDTH  early I2Q2 per channel; channel k occupies bits [k*I2Q2_WIDTH +: I2Q2_WIDTH].
- req_late  in  NUM_CH*I2Q2_WIDTH  late I2Q2 per channel; same packing.
- dll_tag  out  CH_ID_WIDTH  tag presented to the DLL.
- dll_i2q2_early  out  I2Q2_WIDTH  operand held to the DLL.
- dll_i2q2_late  out  I2Q2_WIDTH  operand held to the DLL.
- dll_start  out  1  one-cycle pulse when a new operand set is presented.
- dll_result_ready  in  1  DLL result strobe.
- dll_result_tag  in  CH_ID_WIDTH  tag accompanying the result.
- dll_shift_direction  in  1  result sign.
- dll_shift_amount  in  SHIFT_WIDTH  result magnitude.
- resp_valid  out  NUM_CH  one-hot, one-cycle response strobe.
- resp_shift_direction  out  1  registered copy of the DLL result.
- resp_shift_amount  out  SHIFT_WIDTH  registered copy of the DLL result.
- busy  out  1  high in ISSUE or WAIT.
- overrun  out  NUM_CH  sticky per channel: a request arrived while that channel was already pending.
- tag_err  out  1  sticky: result_ready arrived with an unexpected tag or outside WAIT.

Behaviour:
- Reset (async): state=IDLE; all pending bits cleared; rr_ptr=0; all outputs 0; operand registers 0.
- Capture: req_valid[k] sets pending[k] and latches req_early/late[k] into slot k.
  - If pending[k] is already set (and slot k is not being granted this cycle), the slot is overwritten with the newer data and overrun[k] is set.
  - If req_valid[k] and the grant of k coincide, the grant takes the old slot data; the new data is latched and pending[k] stays set.
- IDLE:
  - If any pending bit is set, grant the lowest index >= rr_ptr, wrapping modulo NUM_CH.
  - On grant: copy slot operands to the dll_* registers, set dll_tag=k, clear pending[k], set rr_ptr=(k+1) mod NUM_CH, go to ISSUE.
  - Request-to-dll_start latency from IDLE with nothing else pending: 2 cycles (capture, then grant).
- ISSUE: dll_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - dll_* outputs are held constant.
  - On dll_result_ready with dll_result_tag==dll_tag: next cycle resp_valid[dll_tag]=1 with the registered direction/amount; go to IDLE.
  - On dll_result_ready with a mismatched tag: ignore the result, set tag_err, stay in WAIT.
- dll_result_ready in IDLE or ISSUE: ignored; tag_err set.
- resp_shift_* hold their last value between strobes.
- Exactly one outstanding DLL operation at any time.
- Starvation bound: a pending channel is served within NUM_CH grants.
- Reset mid-operation: everything returns to reset values; any in-flight result is later flagged by tag_err if it arrives in IDLE.

Optional Feature:
- Macro: DLL_SCHED_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT, return to IDLE with no resp_valid and set sticky output timeout_err (1-bit port present only under the macro).
  - A late result arriving afterwards sets tag_err.
- When undefined: no counter, no port; WAIT is unbounded.

Test Plan:
- Single request: req_valid[2] with early=0x100, late=0x80 -> dll_start 2 cycles later with tag=2 and those operands; return result_ready tag=2, dir=0, amt=5 -> resp_valid=0b0100 next cycle with amt=5.
- Simultaneous req_valid=0b1111 from reset -> grant order 0,1,2,3; dll_start count=4; each resp_valid is one-hot in that order.
- Fairness: channel 0 re-requests after every response while channel 3 is pending -> order 0,1..3 round-robin; channel 3 served before channel 0's second grant.
- Overrun: two req_valid[1] pulses while busy on channel 0 -> overrun=0b0010; the later operands are issued.
- Tag error: in WAIT for tag=1, result_ready with tag=3 -> tag_err=1, no resp_valid, still WAIT; the correct tag=1 result then completes normally.
- Timeout (DLL_SCHED_TIMEOUT_EN, TIMEOUT=16): no result returned -> timeout_err=1 after 16 WAIT cycles; the next pending channel is issued.
